// File: rtl/fp32_pkg.sv
// Shared FP32 constants, FSM state type and canned special values for the
// iterative divider. Used alongside the combinational multiplier datapath.
package fp32_pkg;

    localparam int BIT_WIDTH  = 32;
    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int QBITS      = MANT_WIDTH + 3;
    localparam int BIAS       = (1 << (EXP_WIDTH - 1)) - 1;

    localparam logic [EXP_WIDTH-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Signed zero: sign bit followed by an all-zero magnitude.
    function automatic logic [BIT_WIDTH-1:0] signed_zero(input logic s);
        return {s, {(BIT_WIDTH-1){1'b0}}};
    endfunction

    // Signed infinity: all-ones exponent, zero mantissa.
    function automatic logic [BIT_WIDTH-1:0] signed_inf(input logic s);
        return {s, EXP_MAX, {MANT_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/div_fp32_step.sv
// One combinational restoring-division step: compare the partial remainder
// with the divisor, subtract when it fits, then shift left for the next bit.
module div_fp32_step
    import fp32_pkg::*;
(
    input  logic [MANT_WIDTH+1:0] rem,
    input  logic [MANT_WIDTH:0]   divisor,
    output logic [MANT_WIDTH+1:0] next_rem,
    output logic                  qbit
);

    logic [MANT_WIDTH:0] diff;

    // The remainder is always below twice the divisor, so the difference
    // (or the unchanged remainder when the divisor does not fit) fits in
    // the low MANT_WIDTH+1 bits.
    always_comb begin
        qbit     = (rem >= {1'b0, divisor});
        diff     = qbit ? (rem[MANT_WIDTH:0] - divisor) : rem[MANT_WIDTH:0];
        next_rem = {diff, 1'b0};
    end

endmodule

// File: rtl/div_fp32_seq.sv
// Iterative FP32 divider (result = a_operand / b_operand), restoring division.
// Subnormals flush to zero; NaN/Inf inputs give signed zero; round half-up.
// Build option DIV_FP32_RADIX4_EN chains two restoring steps per cycle
// (13 DIVIDE cycles instead of 26) with bit-identical results.
//
// Handshake: an operation is accepted on a rising edge where in_valid and
// in_ready are both high; a result is consumed on a rising edge where
// out_valid and out_ready are both high. result/div_by_zero stay stable
// while out_valid is high and not yet consumed. Only one operation is in
// flight: in_ready is high only in IDLE.
module div_fp32_seq
    import fp32_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a_operand,
    input  logic [BIT_WIDTH-1:0] b_operand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 div_by_zero,
    output state_t               dbg_state_o
);

`ifdef DIV_FP32_RADIX4_EN
    localparam logic [4:0] CNT_LAST = 5'(QBITS / 2 - 1);
`else
    localparam logic [4:0] CNT_LAST = 5'(QBITS - 1);
`endif

    state_t                 state_q;
    logic                   sign_q;
    logic [EXP_WIDTH-1:0]   ea_q;
    logic [EXP_WIDTH-1:0]   eb_q;
    logic [MANT_WIDTH+1:0]  rem_q;
    logic [MANT_WIDTH:0]    div_q;
    logic [QBITS-1:0]       quo_q;
    logic [4:0]             cnt_q;
    logic [BIT_WIDTH-1:0]   result_q;
    logic                   dbz_q;
    logic                   out_valid_q;
    logic                   in_ready_q;

    logic [MANT_WIDTH+1:0]  rem_d;
    logic [QBITS-1:0]       quo_d;
    logic [MANT_WIDTH+1:0]  rem_s0;
    logic                   qbit_s0;

    // Operand fields seen while IDLE.
    logic                   in_sign;
    logic [EXP_WIDTH-1:0]   a_exp;
    logic [EXP_WIDTH-1:0]   b_exp;

    // Rounding / exponent datapath, evaluated while in ROUND.
    logic                   norm;
    logic [MANT_WIDTH-1:0]  mant;
    logic                   guard;
    logic [MANT_WIDTH:0]    mant_r;
    logic                   carry;
    logic signed [9:0]      exp_d;
    logic [BIT_WIDTH-1:0]   round_res_d;

    assign in_sign = a_operand[BIT_WIDTH-1] ^ b_operand[BIT_WIDTH-1];
    assign a_exp   = a_operand[BIT_WIDTH-2:MANT_WIDTH];
    assign b_exp   = b_operand[BIT_WIDTH-2:MANT_WIDTH];

    div_fp32_step u_step0 (
        .rem      (rem_q),
        .divisor  (div_q),
        .next_rem (rem_s0),
        .qbit     (qbit_s0)
    );

`ifdef DIV_FP32_RADIX4_EN
    logic [MANT_WIDTH+1:0]  rem_s1;
    logic                   qbit_s1;

    div_fp32_step u_step1 (
        .rem      (rem_s0),
        .divisor  (div_q),
        .next_rem (rem_s1),
        .qbit     (qbit_s1)
    );

    // Two quotient bits per cycle, earlier step lands in the higher bit.
    always_comb begin
        rem_d = rem_s1;
        quo_d = {quo_q[QBITS-3:0], qbit_s0, qbit_s1};
    end
`else
    // One quotient bit per cycle shifted in at the bottom.
    always_comb begin
        rem_d = rem_s0;
        quo_d = {quo_q[QBITS-2:0], qbit_s0};
    end
`endif

    // Normalise the 26-bit quotient, round half-up on the guard bit and
    // form the biased exponent with overflow/underflow saturation.
    always_comb begin
        norm   = quo_q[QBITS-1];
        mant   = norm ? quo_q[QBITS-2:2] : quo_q[QBITS-3:1];
        guard  = norm ? quo_q[1] : quo_q[0];
        mant_r = {1'b0, mant} + {{MANT_WIDTH{1'b0}}, guard};
        carry  = mant_r[MANT_WIDTH];
        exp_d  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
               + 10'(BIAS - 1)
               + $signed({9'b0, norm}) + $signed({9'b0, carry});
        if (exp_d >= 10'sd255) begin
            round_res_d = signed_inf(sign_q);
        end else if (exp_d <= 10'sd0) begin
            round_res_d = signed_zero(sign_q);
        end else begin
            round_res_d = {sign_q, exp_d[EXP_WIDTH-1:0],
                           carry ? {MANT_WIDTH{1'b0}} : mant_r[MANT_WIDTH-1:0]};
        end
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sign_q     <= in_sign;
                        ea_q       <= a_exp;
                        eb_q       <= b_exp;
                        rem_q      <= {2'b01, a_operand[MANT_WIDTH-1:0]};
                        div_q      <= {1'b1, b_operand[MANT_WIDTH-1:0]};
                        quo_q      <= '0;
                        cnt_q      <= '0;
                        dbz_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        if (a_exp == EXP_MAX || b_exp == EXP_MAX) begin
                            result_q    <= signed_zero(in_sign);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (b_exp == '0) begin
                            result_q    <= signed_inf(in_sign);
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else if (a_exp == '0) begin
                            result_q    <= signed_zero(in_sign);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    result_q    <= round_res_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_fp32_seq.sv
// Bench for div_fp32_seq: directed cases, randomized operands against a
// behavioural model, backpressure, busy-time input, and mid-divide reset.
module tb_div_fp32_seq;
    import fp32_pkg::*;

`ifdef DIV_FP32_RADIX4_EN
    localparam int NORM_LAT = 15;
`else
    localparam int NORM_LAT = 28;
`endif

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_fp32_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_operand   (a_operand),
        .b_operand   (b_operand),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero),
        .dbg_state_o (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z,
                                  output int lat);
        logic   s;
        int     ea, eb, e, norm, carry;
        longint sa, sb, q, mant, guard, mr;
        s   = a[31] ^ b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        z   = 1'b0;
        lat = 1;
        if (ea == 255 || eb == 255) begin
            r = {s, 31'b0};
        end else if (eb == 0) begin
            r = {s, 8'hFF, 23'b0};
            z = 1'b1;
        end else if (ea == 0) begin
            r = {s, 31'b0};
        end else begin
            lat = NORM_LAT;
            sa  = 64'(a[22:0]) + 64'd8388608;
            sb  = 64'(b[22:0]) + 64'd8388608;
            q   = (sa * 64'd33554432) / sb;
            if (q >= 64'd33554432) begin
                norm = 1; mant = (q / 4) % 8388608; guard = (q / 2) % 2;
            end else begin
                norm = 0; mant = (q / 2) % 8388608; guard = q % 2;
            end
            mr = mant + guard;
            carry = 0;
            if (mr == 64'd8388608) begin
                mr = 0; carry = 1;
            end
            e = ea - eb + 127 - 1 + norm + carry;
            if (e >= 255)     r = {s, 8'hFF, 23'b0};
            else if (e <= 0)  r = {s, 31'b0};
            else              r = {s, 8'(e), 23'(mr)};
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        logic       s;
        int         k;
        k = int'($urandom_range(0, 15));
        if (k == 0)      e = 8'd0;
        else if (k == 1) e = 8'd255;
        else if (k < 7)  e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(110, 144));
        s = 1'($urandom_range(0, 1));
        return {s, e, 23'($urandom())};
    endfunction

    // ---------------- driver tasks ----------------
    // Waits for in_ready, presents operands for one accept edge, then counts
    // cycles (sampled on falling edges) until out_valid. out_ready stays low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic dbz,
                          output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL in_ready_wait got=0 want=1");
        end
        a_operand = a;
        b_operand = b;
        in_valid  = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 100);
        res = result;
        dbz = div_by_zero;
    endtask

    // Called at a falling edge with out_valid high: consume the result.
    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_operand = '0; b_operand = '0;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=00000000", result); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] ta [7];
        logic [31:0] tb_ [7];
        logic [31:0] texp [7];
        logic        tz [7];
        int          tl [7];
        logic [31:0] res;
        logic        dbz;
        int          lat;
        ta[0] = 32'h40C00000; tb_[0] = 32'h40000000; texp[0] = 32'h40400000; tz[0] = 1'b0; tl[0] = NORM_LAT;
        ta[1] = 32'h3F800000; tb_[1] = 32'h40400000; texp[1] = 32'h3EAAAAAB; tz[1] = 1'b0; tl[1] = NORM_LAT;
        ta[2] = 32'hBF800000; tb_[2] = 32'h00000000; texp[2] = 32'hFF800000; tz[2] = 1'b1; tl[2] = 1;
        ta[3] = 32'h7F800000; tb_[3] = 32'h3F800000; texp[3] = 32'h00000000; tz[3] = 1'b0; tl[3] = 1;
        ta[4] = 32'h7F000000; tb_[4] = 32'h3E800000; texp[4] = 32'h7F800000; tz[4] = 1'b0; tl[4] = NORM_LAT;
        ta[5] = 32'h00800000; tb_[5] = 32'h40000000; texp[5] = 32'h00000000; tz[5] = 1'b0; tl[5] = NORM_LAT;
        ta[6] = 32'h00000000; tb_[6] = 32'hC0000000; texp[6] = 32'h80000000; tz[6] = 1'b0; tl[6] = 1;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb_[i], res, dbz, lat);
            total++; if (res !== texp[i]) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, texp[i]); end
            total++; if (dbz !== tz[i]) begin bad++; $display("FAIL dir%0d_dbz got=%b want=%b", i, dbz, tz[i]); end
            total++; if (lat != tl[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, tl[i]); end
            finish_op();
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_in_ready_after got=%b want=1", i, in_ready); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp_r;
        logic        dbz, exp_z;
        int          lat, exp_l;
        for (int i = 0; i < 60; i++) begin
            a = rand_fp();
            b = rand_fp();
            model(a, b, exp_r, exp_z, exp_l);
            run_op(a, b, res, dbz, lat);
            total++; if (res !== exp_r) begin bad++; $display("FAIL rnd_result a=%h b=%h got=%h want=%h", a, b, res, exp_r); end
            total++; if (dbz !== exp_z) begin bad++; $display("FAIL rnd_dbz a=%h b=%h got=%b want=%b", a, b, dbz, exp_z); end
            total++; if (lat != exp_l) begin bad++; $display("FAIL rnd_latency a=%h b=%h got=%0d want=%0d", a, b, lat, exp_l); end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic        dbz;
        int          lat;
        run_op(32'h40C00000, 32'h40000000, res, dbz, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (result !== 32'h40400000) begin bad++; $display("FAIL bp_hold_result got=%h want=40400000", result); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready got=%b want=0", in_ready); end
        end
        finish_op();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    endtask

    // in_valid stays high with other operands while busy; they must be ignored.
    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        a_operand = 32'h3F800000;
        b_operand = 32'h40400000;
        in_valid  = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            a_operand = 32'h7F800000;
            b_operand = 32'h00000000;
        end while (!out_valid && lat < 100);
        total++; if (result !== 32'h3EAAAAAB) begin bad++; $display("FAIL busy_result got=%h want=3eaaaaab", result); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL busy_dbz got=%b want=0", div_by_zero); end
        total++; if (lat != NORM_LAT) begin bad++; $display("FAIL busy_latency got=%0d want=%0d", lat, NORM_LAT); end
        in_valid = 1'b0;
        finish_op();
    endtask

    task automatic test_mid_reset();
        logic [31:0] res;
        logic        dbz;
        int          lat;
        // Leave a nonzero result and div_by_zero behind first.
        run_op(32'hBF800000, 32'h00000000, res, dbz, lat);
        finish_op();
        @(negedge clk);
        a_operand = 32'h40C00000;
        b_operand = 32'h40000000;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        total++; if (dbg_state !== DIVIDE) begin bad++; $display("FAIL mr_pre_state got=%0d want=%0d", dbg_state, DIVIDE); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mr_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mr_in_ready got=%b want=1", in_ready); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL mr_result got=%h want=00000000", result); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL mr_state got=%0d want=%0d", dbg_state, IDLE); end
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h40C00000, 32'h40000000, res, dbz, lat);
        total++; if (res !== 32'h40400000) begin bad++; $display("FAIL mr_fresh_result got=%h want=40400000", res); end
        total++; if (lat != NORM_LAT) begin bad++; $display("FAIL mr_fresh_latency got=%0d want=%0d", lat, NORM_LAT); end
        finish_op();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_busy_ignore();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
